// File: rtl/seg7_sweep_checker.sv
// seg7_sweep_checker
//   Receiving end of the seven-segment path. Reverse-decodes each accepted
//   7-bit segment pattern (bit6=a .. bit0=g) to its hex value and compares it
//   against an internally generated sweep (START_DIGIT, +1, wrapping 15->0).
//   It counts mismatches (saturating), captures the first failing beat and
//   reports pass/fail once NUM_BEATS patterns have been accepted.
//
// Parameters
//   NUM_BEATS   patterns per sweep (1..255)
//   START_DIGIT first expected hex value (0..15)
//   ERR_W       error counter width, saturates at 2**ERR_W-1
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             single-cycle pulse, begins a sweep from IDLE or DONE
//   seg_valid, seg    incoming pattern and its qualifier
//   seg_ready         pattern accepted this cycle when seg_valid is high
//   out_valid         one-cycle pulse, digit/digit_ok/match just updated
//   digit, digit_ok   decoded value and legal-glyph flag
//   match             legal glyph and equal to the expected sweep value
//   err_count         mismatches in the current sweep
//   first_err_idx     beat index of first mismatch (8'hFF = none yet)
//   first_err_seg     pattern of first mismatch, active-high polarity
//   busy, done, pass  sweep running, sweep finished, finished clean
//
// Build option
//   SEG7_ACTIVE_LOW_EN  seg is treated as active-low (common-anode) and
//                       inverted before decode and before error capture.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SWEEP | accepting patterns, one per handshake
// DONE  | sweep finished, results and error capture held until next start

module seg7_sweep_checker #(
  parameter int NUM_BEATS   = 16,
  parameter int START_DIGIT = 0,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seg_valid,
  input  logic [6:0]       seg,
  output logic             seg_ready,
  output logic             out_valid,
  output logic [3:0]       digit,
  output logic             digit_ok,
  output logic             match,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_err_idx,
  output logic [6:0]       first_err_seg,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0]       START_HEX = 4'(START_DIGIT);
  localparam logic [7:0]       LAST_BEAT = 8'(NUM_BEATS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [7:0]       NO_ERR    = 8'hFF;

  state_t     state, state_nxt;
  logic [3:0] expected;
  logic [7:0] beat;
  logic [6:0] seg_pol;
  logic [3:0] dec_digit;
  logic       dec_ok;
  logic       dec_match;
  logic       accept;
  logic       sweep_clear;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_pol = ~seg;
`else
  assign seg_pol = seg;
`endif

  always_comb begin
    dec_digit = 4'h0;
    dec_ok    = 1'b1;
    case (seg_pol)
      7'h7E:   dec_digit = 4'h0;
      7'h30:   dec_digit = 4'h1;
      7'h6D:   dec_digit = 4'h2;
      7'h79:   dec_digit = 4'h3;
      7'h33:   dec_digit = 4'h4;
      7'h5B:   dec_digit = 4'h5;
      7'h5F:   dec_digit = 4'h6;
      7'h70:   dec_digit = 4'h7;
      7'h7F:   dec_digit = 4'h8;
      7'h7B:   dec_digit = 4'h9;
      7'h77:   dec_digit = 4'hA;
      7'h1F:   dec_digit = 4'hB;
      7'h4E:   dec_digit = 4'hC;
      7'h3D:   dec_digit = 4'hD;
      7'h4F:   dec_digit = 4'hE;
      7'h47:   dec_digit = 4'hF;
      default: dec_ok    = 1'b0;
    endcase
  end

  assign dec_match = dec_ok && (dec_digit == expected);
  assign accept    = seg_valid && seg_ready;
  assign pass      = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // start is only honoured outside SWEEP; seg_ready is low there, so a
  // pattern presented alongside start is never consumed.
  always_comb begin
    state_nxt   = state;
    sweep_clear = 1'b0;
    seg_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SWEEP;
          sweep_clear = 1'b1;
        end
      end
      SWEEP: begin
        seg_ready = 1'b1;
        busy      = 1'b1;
        if (accept && (beat == LAST_BEAT)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt   = SWEEP;
          sweep_clear = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      digit         <= 4'h0;
      digit_ok      <= 1'b0;
      match         <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      first_err_seg <= 7'h00;
      expected      <= START_HEX;
      beat          <= 8'h00;
    end else begin
      out_valid <= accept;
      if (sweep_clear) begin
        err_count     <= '0;
        first_err_idx <= NO_ERR;
        first_err_seg <= 7'h00;
        expected      <= START_HEX;
        beat          <= 8'h00;
      end else if (accept) begin
        digit    <= dec_digit;
        digit_ok <= dec_ok;
        match    <= dec_match;
        expected <= expected + 4'd1;
        beat     <= beat + 8'd1;
        if (!dec_match) begin
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          if (first_err_idx == NO_ERR) begin
            first_err_idx <= beat;
            first_err_seg <= seg_pol;
          end
        end
      end
    end
  end

endmodule

// File: doc/seg7_sweep_checker.md
Name: seg7_sweep_checker

Overview:
- Receiving end of the seven-segment path: accepts 7-bit segment patterns (a..g) from a hex-to-segment decoder under test and reverse-decodes each one to its 4-bit hex value.
- Checks each decoded value against an internally generated expected sweep (START_DIGIT, +1, wrap 15->0) and counts mismatches.
- Captures the first failure and reports pass/fail at end of sweep.
- Sits downstream of the segment functions as an on-chip self-check, replacing manual $monitor inspection.

Parameters:
- NUM_BEATS, 16: patterns per sweep (1..255).
- START_DIGIT, 0: first expected hex value (0..15).
- ERR_W, 5: error counter width; counter saturates at 2^ERR_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sweep.
- seg_valid  in  1  seg carries a pattern.
- seg  in  7  pattern, bit6=a ... bit0=g, active-high.
- seg_ready  out  1  checker accepts a pattern this cycle.
- out_valid  out  1  one-cycle pulse; digit/digit_ok/match are updated.
- digit  out  4  decoded hex value.
- digit_ok  out  1  pattern is one of the 16 legal glyphs.
- match  out  1  digit_ok and digit==expected.
- err_count  out  ERR_W  mismatches this sweep, saturating.
- first_err_idx  out  8  beat index of the first mismatch.
- first_err_seg  out  7  pattern of the first mismatch.
- busy  out  1  high in SWEEP.
- done  out  1  high in DONE.
- pass  out  1  done and err_count==0.

Behaviour:
- Legal glyph table (hex digit -> seg): 0->7E, 1->30, 2->6D, 3->79, 4->33, 5->5B, 6->5F, 7->70, 8->7F, 9->7B, A->77, b->1F, C->4E, d->3D, E->4F, F->47. Any other pattern is illegal: digit=0, digit_ok=0.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except first_err_idx=8'hFF and first_err_seg=0.
  - Internal expected=START_DIGIT; beat=0.
- FSM IDLE:
  - seg_ready=0.
  - start -> SWEEP; clear err_count, first_err_idx=FF, first_err_seg=0; expected=START_DIGIT; beat=0.
- FSM SWEEP:
  - seg_ready=1, busy=1.
  - Handshake = seg_valid & seg_ready.
  - On handshake, registered results appear next cycle (latency 1): out_valid=1, digit, digit_ok, match.
  - On a mismatch (match=0):
    - err_count+1, saturating.
    - If first_err_idx==FF, capture first_err_idx=beat and first_err_seg=seg.
  - expected increments modulo 16 (F->0 wraps silently; not an error).
  - beat increments.
  - When the handshake is beat NUM_BEATS-1 -> DONE, on the same edge the results register.
- SWEEP, other rules:
  - seg_valid=0: hold state; out_valid=0.
  - start is ignored.
- FSM DONE:
  - seg_ready=0, done=1, pass=(err_count==0).
  - Results and error capture held.
  - start -> SWEEP with the same clears as from IDLE.
- out_valid is high for exactly one cycle per accepted pattern.
- digit/digit_ok/match hold their last values between pulses.
- seg_valid while seg_ready=0: ignored, no side effects.
- Reset mid-sweep: immediate return to reset values; partial sweep is discarded.
- Simultaneous start and seg_valid in IDLE/DONE: only start acts; that pattern is not consumed.

Optional Feature:
- SEG7_ACTIVE_LOW_EN defined:
  - seg is inverted before decode and before first_err_seg capture (common-anode displays).
  - first_err_seg stores the decoded-polarity (active-high) pattern.
- Undefined: seg is used as-is, active-high.
- No port or timing change in either case.

Test Plan:
- Reset, start, 16 correct patterns 7E,30,...,47, seg_valid held high -> 16 out_valid pulses, match=1 each, done=1, pass=1, err_count=0, first_err_idx=FF.
- Sweep with beat 5 driving 5F instead of 5B -> digit=6, digit_ok=1, match=0; final err_count=1, first_err_idx=5, first_err_seg=5F, pass=0.
- Beat 2 driving 00 (illegal) and beat 9 driving 7F -> err_count=2, first_err_idx=2, first_err_seg=00, digit_ok=0 on beat 2.
- START_DIGIT=15: first pattern 47, then 7E -> both match (wrap F->0); seg_valid toggled 1/0 every cycle -> out_valid only after accepted beats, done after beat 16.
- Start, 7 patterns, rst_n=0 -> all outputs to reset values; then start plus 16 correct patterns -> pass=1; start pulses mid-sweep have no effect.
- ERR_W=2, all 16 patterns wrong -> err_count saturates at 3; with SEG7_ACTIVE_LOW_EN, inverted table (01,4F,...) -> pass=1.
